// File: rtl/seven_segment_mux_if.sv
// Load handshake bundle for seven_segment_mux: the value to show, its decimal
// points, the load strobe and the acknowledge pulse.
interface seven_segment_mux_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] i_Number;
  logic [NUM_DIGITS-1:0]   i_Dp;
  logic                    i_Load;
  logic                    o_Load_Ack;

  modport master (
    output i_Number,
    output i_Dp,
    output i_Load,
    input  o_Load_Ack
  );

  modport slave (
    input  i_Number,
    input  i_Dp,
    input  i_Load,
    output o_Load_Ack
  );
endinterface

// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit seven-segment driver: scan prescaler, inter-digit
// blanking, leading-zero suppression and a load that swaps only at frame boundaries.
module seven_segment_mux #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_DIG = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Enable,
  input  logic                  i_Lz_Blank,
  seven_segment_mux_if.slave    load_if,
  output logic                  o_Frame_Done,
  output logic [6:0]            o_Segment,
  output logic                  o_Dp,
  output logic [NUM_DIGITS-1:0] o_Digit_En
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic SEG_OFF = (ACTIVE_LOW_SEG != 0);
  localparam logic DIG_OFF = (ACTIVE_LOW_DIG != 0);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_num_q, disp_num_d, shd_num_q, shd_num_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, shd_dp_q, shd_dp_d;
  logic                    pending_q, pending_d;
  logic                    lz_q, lz_d;
  logic                    load_ack_q, load_ack_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;

  logic                    boundary;
  logic                    zero_run;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic [3:0]              cur_nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h7E;  4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;  4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;  4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;  4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h7B;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;  4'hD: glyph = 7'h3D;
      4'hE: glyph = 7'h4F;  default: glyph = 7'h47;
    endcase
  endfunction

  always_comb begin
    pre_d    = pre_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!i_Enable) begin
      pre_d = '0;
      idx_d = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // A load on the boundary cycle bypasses the shadow so pending never lingers.
  always_comb begin
    shd_num_d  = shd_num_q;
    shd_dp_d   = shd_dp_q;
    pending_d  = pending_q;
    disp_num_d = disp_num_q;
    disp_dp_d  = disp_dp_q;
    load_ack_d = 1'b0;
    if (load_if.i_Load) begin
      shd_num_d = load_if.i_Number;
      shd_dp_d  = load_if.i_Dp;
      pending_d = 1'b1;
    end
    if (boundary && (pending_q || load_if.i_Load)) begin
      disp_num_d = load_if.i_Load ? load_if.i_Number : shd_num_q;
      disp_dp_d  = load_if.i_Load ? load_if.i_Dp     : shd_dp_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
  end

  always_comb begin
    zero_run = 1'b1;
    lz_dark  = '0;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (disp_num_q[4*k +: 4] == 4'h0);
      lz_dark[k] = lz_q & zero_run;
    end
    cur_nib      = disp_num_q[{idx_q, 2'b00} +: 4];
    dark         = !i_Enable || (pre_q < BLANK_END) || lz_dark[idx_q];
    seg_d        = dark ? {7{SEG_OFF}} : (glyph(cur_nib) ^ {7{SEG_OFF}});
    dp_d         = dark ? SEG_OFF : (disp_dp_q[idx_q] ^ SEG_OFF);
    dig_en_d     = {NUM_DIGITS{DIG_OFF}};
    if (!dark) dig_en_d[idx_q] = ~DIG_OFF;
    lz_d         = i_Lz_Blank;
    frame_done_d = boundary;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      disp_num_q   <= '0;
      disp_dp_q    <= '0;
      shd_num_q    <= '0;
      shd_dp_q     <= '0;
      pending_q    <= 1'b0;
      lz_q         <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= {7{SEG_OFF}};
      dp_q         <= SEG_OFF;
      dig_en_q     <= {NUM_DIGITS{DIG_OFF}};
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      disp_num_q   <= disp_num_d;
      disp_dp_q    <= disp_dp_d;
      shd_num_q    <= shd_num_d;
      shd_dp_q     <= shd_dp_d;
      pending_q    <= pending_d;
      lz_q         <= lz_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_en_q     <= dig_en_d;
    end
  end

  assign load_if.o_Load_Ack = load_ack_q;
  assign o_Frame_Done       = frame_done_q;
  assign o_Segment          = seg_q;
  assign o_Dp               = dp_q;
  assign o_Digit_En         = dig_en_q;

endmodule
